// File: rtl/ecc_119_pkg.sv
// Shared constants and code-layout helpers for the 119-bit SECDED write path.
package ecc_119_pkg;

  localparam int DATA_WIDTH   = 119;
  localparam int PARITY_WIDTH = 8;
  localparam int HAM_WIDTH    = 7;

  // Flips two Hamming bits and leaves overall parity untouched, so a
  // downstream decoder classifies the word as a double-bit error.
  localparam logic [PARITY_WIDTH-1:0] POISON_MASK = 8'h03;

  // Codeword position (1..126) of data bit idx. Data fills the positions
  // that are not powers of two, in ascending order.
  function automatic logic [HAM_WIDTH-1:0] data_pos(input int unsigned idx);
    int unsigned pos;
    pos = idx + 32'd1;
    for (int k = 0; k < HAM_WIDTH; k++) begin
      if (pos >= (32'd1 << k)) begin
        pos = pos + 32'd1;
      end else begin
        pos = pos;
      end
    end
    return pos[HAM_WIDTH-1:0];
  endfunction

  // Even-parity helper used for the overall parity bit.
  function automatic logic xor_all(input logic [DATA_WIDTH-1:0] data,
                                   input logic [HAM_WIDTH-1:0] ham);
    return (^data) ^ (^ham);
  endfunction

endpackage

// File: rtl/ecc_119_enc.sv
// Purely combinational SECDED encoder: 119 data bits in, 8 parity bits out.
module ecc_119_enc
  import ecc_119_pkg::*;
(
  input  logic [DATA_WIDTH-1:0]   data,
  output logic [PARITY_WIDTH-1:0] parity
);

  logic [HAM_WIDTH-1:0] ham_s;

  // Hamming bit k collects every data bit whose codeword position has bit k set.
  always_comb begin
    ham_s = {HAM_WIDTH{1'b0}};
    for (int i = 0; i < DATA_WIDTH; i++) begin
      ham_s = ham_s ^ ({HAM_WIDTH{data[i]}} & data_pos(i));
    end
    parity = {xor_all(data, ham_s), ham_s};
  end

endmodule

// File: rtl/ecc_119_enc_pipe.sv
// Two-stage SECDED write pipeline with redundant encoders, parity poisoning
// on encoder disagreement, fault accounting and one-shot error injection.
module ecc_119_enc_pipe
  import ecc_119_pkg::*;
#(
  parameter int FCNT_WIDTH = 8
)
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_WIDTH-1:0]   s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_WIDTH-1:0]   m_data,
  output logic [PARITY_WIDTH-1:0] m_parity,
  output logic                    m_fault,
  input  logic                    ecc_fault_detc_en,
  input  logic                    bypass,
  input  logic                    inj_arm,
  input  logic                    inj_dbl,
  input  logic                    fault_clr,
  output logic                    fault_sticky,
  output logic [FCNT_WIDTH-1:0]   fault_cnt
);

  localparam logic [FCNT_WIDTH-1:0] CNT_ONE = {{(FCNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [FCNT_WIDTH-1:0] CNT_MAX = {FCNT_WIDTH{1'b1}};

  // Pipeline state
  logic                    v1_r;
  logic [DATA_WIDTH-1:0]   d1_r;
  logic                    v2_r;
  logic [DATA_WIDTH-1:0]   m_data_r;
  logic [PARITY_WIDTH-1:0] m_parity_r;
  logic                    m_fault_r;

  // Injection and fault bookkeeping
  logic                    inj_armed_r;
  logic                    inj_dbl_r;
  logic                    fault_sticky_r;
  logic [FCNT_WIDTH-1:0]   fault_cnt_r;

  // Both encoder copies must survive synthesis for the comparison to mean anything.
  (* keep = "true" *) logic [PARITY_WIDTH-1:0] par_a_s;
  (* keep = "true" *) logic [PARITY_WIDTH-1:0] par_b_s;

  logic                    rdy1_s;
  logic                    acc_s;
  logic                    xfer_s;
  logic                    fault_s;
  logic                    inj_now_s;
  logic                    inj_mode_s;
  logic                    count_s;
  logic [PARITY_WIDTH-1:0] par_out_s;
  logic [DATA_WIDTH-1:0]   inj_mask_s;
  logic [FCNT_WIDTH-1:0]   cnt_inc_s;

  (* keep = "true" *) ecc_119_enc u_enc_a (.data(d1_r), .parity(par_a_s));
  (* keep = "true" *) ecc_119_enc u_enc_b (.data(d1_r), .parity(par_b_s));

  // Handshake: S1 may move on whenever S2 is empty or draining this cycle.
  always_comb begin
    rdy1_s  = ~v2_r | m_ready;
    s_ready = ~v1_r | rdy1_s;
    acc_s   = s_valid & s_ready;
    xfer_s  = v1_r & rdy1_s;
  end

  // Encoder comparison, output parity selection and injection mask for the S1->S2 beat.
  always_comb begin
    fault_s    = ecc_fault_detc_en & ~bypass & (par_a_s != par_b_s);
    inj_now_s  = inj_armed_r | inj_arm;
    inj_mode_s = inj_arm ? inj_dbl : inj_dbl_r;
    count_s    = xfer_s & fault_s & ~inj_now_s;
    if (bypass) begin
      par_out_s = {PARITY_WIDTH{1'b0}};
    end else if (fault_s) begin
      par_out_s = par_a_s ^ POISON_MASK;
    end else begin
      par_out_s = par_a_s;
    end
    if (inj_now_s) begin
      inj_mask_s = {{(DATA_WIDTH-2){1'b0}}, inj_mode_s, 1'b1};
    end else begin
      inj_mask_s = {DATA_WIDTH{1'b0}};
    end
    if (fault_cnt_r == CNT_MAX) begin
      cnt_inc_s = fault_cnt_r;
    end else begin
      cnt_inc_s = fault_cnt_r + CNT_ONE;
    end
  end

  // Stage 1: capture accepted input beats, empty when the beat moves on.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r <= 1'b0;
      d1_r <= {DATA_WIDTH{1'b0}};
    end else if (acc_s) begin
      v1_r <= 1'b1;
      d1_r <= s_data;
    end else if (xfer_s) begin
      v1_r <= 1'b0;
    end
  end

  // Stage 2: registered output beat, held stable while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_r       <= 1'b0;
      m_data_r   <= {DATA_WIDTH{1'b0}};
      m_parity_r <= {PARITY_WIDTH{1'b0}};
      m_fault_r  <= 1'b0;
    end else if (xfer_s) begin
      v2_r       <= 1'b1;
      m_data_r   <= d1_r ^ inj_mask_s;
      m_parity_r <= par_out_s;
      m_fault_r  <= fault_s;
    end else if (m_ready) begin
      v2_r <= 1'b0;
    end
  end

  // Injection flag: armed by a pulse, consumed by the next S1->S2 transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      inj_armed_r <= 1'b0;
      inj_dbl_r   <= 1'b0;
    end else if (xfer_s) begin
      inj_armed_r <= 1'b0;
    end else if (inj_arm) begin
      inj_armed_r <= 1'b1;
      inj_dbl_r   <= inj_dbl;
    end
  end

  // Fault accounting: a coincident clear is applied before the new fault is counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_sticky_r <= 1'b0;
      fault_cnt_r    <= {FCNT_WIDTH{1'b0}};
    end else if (count_s) begin
      fault_sticky_r <= 1'b1;
      fault_cnt_r    <= fault_clr ? CNT_ONE : cnt_inc_s;
    end else if (fault_clr) begin
      fault_sticky_r <= 1'b0;
      fault_cnt_r    <= {FCNT_WIDTH{1'b0}};
    end
  end

  assign m_valid      = v2_r;
  assign m_data       = m_data_r;
  assign m_parity     = m_parity_r;
  assign m_fault      = m_fault_r;
  assign fault_sticky = fault_sticky_r;
  assign fault_cnt    = fault_cnt_r;

endmodule

// File: doc/ecc_119_enc_pipe.md
# ecc_119_enc_pipe

Write-side companion of the 119-bit SECDED decode path. It accepts 119-bit data beats on a valid/ready interface and computes the 8-bit SECDED parity with two redundant encoder instances whose outputs are compared. It emits data plus parity through a 2-stage pipeline with full throughput and backpressure. On an encoder mismatch it poisons the parity so that any downstream decoder reports a double-bit error. It also keeps a sticky fault flag and a fault counter, and provides one-shot error injection for end-to-end checking of the read path.

## Interface
- DATA_WIDTH, 119, data bits per beat
- PARITY_WIDTH, 8, SECDED parity bits (7 Hamming + 1 overall)
- FCNT_WIDTH, 8, width of the saturating fault counter
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, synchronous, active-high
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid & s_ready
- s_data  in  DATA_WIDTH  write data
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accepts when m_valid & m_ready
- m_data  out  DATA_WIDTH  data, possibly with injected errors
- m_parity  out  PARITY_WIDTH  parity, possibly poisoned
- m_fault  out  1  this beat had an encoder mismatch
- ecc_fault_detc_en  in  1  enables the comparison and poisoning
- bypass  in  1  forces parity to 0 and disables comparison
- inj_arm  in  1  pulse that arms injection for the next beat loaded into stage 2
- inj_dbl  in  1  sampled with inj_arm: 0 flips m_data[0]; 1 flips m_data[1:0]
- fault_clr  in  1  clears the sticky flag and the counter
- fault_sticky  out  1  set on any fault since the last clear or reset
- fault_cnt  out  FCNT_WIDTH  number of faulted beats, saturating at all-ones

## Operation
- **Code definition.** Codeword positions run 1..126. Power-of-two positions hold parity[6:0]: position 2^k holds parity[k]. Data bits fill the remaining positions in ascending order, so data[0] sits at position 3 and data[118] at position 126. parity[k] is the XOR of the data bits whose position has bit k set. parity[7] is the XOR of all data bits and parity[6:0], which gives even overall parity.
- **Stage 1 (S1).** Registers s_data on acceptance.
- **S1 to S2.** Encoders A and B both encode the S1 register combinationally. S2 registers the data, the parity, the fault bit and any injection.
- **Fault.** fault = ecc_fault_detc_en & ~bypass & (parA != parB).
- **Parity output.** When fault=1, m_parity = parA ^ 8'h03. This flips two Hamming bits and leaves overall parity unchanged, so a decoder sees a double error. Otherwise m_parity = parA.
- **Bypass.** When bypass=1, m_parity = 0 and m_fault = 0. bypass is sampled at the S1→S2 transfer.
- **Injection.** A flag is armed by inj_arm, and the mode is taken from inj_dbl. The flag is consumed by the next S1→S2 transfer: that beat's m_data is XORed with 1 or 3 after parity is computed, then the flag clears.
  - inj_arm while already armed updates the mode only.
  - inj_arm in the same cycle as a consuming transfer applies to the current beat and leaves the flag clear.
  - Injected beats are not counted as faults.
- **Fault accounting.** On each S1→S2 transfer with fault=1: fault_sticky is set and fault_cnt increments, saturating at 2^FCNT_WIDTH-1. If fault_clr coincides with a fault, the clear is applied first, so the result is sticky=1 and cnt=1.

## Timing
- **Reset values.** Reset clears:
  - S1 and S2 valid bits
  - m_data = 0, m_parity = 0, m_fault = 0
  - the injection flag
  - fault_sticky = 0, fault_cnt = 0

  Beats in flight are dropped. s_ready = 1 in the first cycle after reset.
- **Ready logic.**
  - s_ready = ~v1 | rdy1, where rdy1 = ~v2 | m_ready.
  - S1→S2 transfer occurs when v1 & rdy1.
  - s_ready is combinational from m_ready.
- **Latency.** A beat accepted at edge N is presented with m_valid=1 after edge N+1 and can be taken by downstream at edge N+2 when there is no stall. Throughput is one beat per cycle.
- **Stall.** While m_valid & ~m_ready, m_data, m_parity and m_fault hold stable. Beats are never dropped or duplicated. Both stages full means s_ready=0.
- **Simultaneous accept and drain.** The same edge may accept into S1, transfer S1→S2 and retire from S2.

## Structure
- **Package ecc_119_pkg.** Holds DATA_WIDTH, PARITY_WIDTH, the poison mask 8'h03, and a function mapping data index to codeword position.
- **Sub-module ecc_119_enc.** Purely combinational: data in, parity out. It is instantiated twice (A and B). Synthesis must keep both copies (keep attribute) so that the comparison is meaningful.

## Test plan
- **Basic encode.** After reset, send s_data=0, then s_data with only bit 0 set, m_ready=1 → m_parity 8'h00 then 8'h83; each beat has m_valid two cycles after acceptance; fault_cnt=0.
- **Throughput and backpressure.** Send 8 back-to-back beats while m_ready toggles randomly → outputs arrive in order with no loss or duplicates; outputs stay stable during stalls; s_ready=0 only when both stages are full.
- **Forced mismatch.** Force encoder B's output bit 0, ecc_fault_detc_en=1 → m_fault=1, m_parity = parA^8'h03, fault_sticky=1, fault_cnt increments per beat. With ecc_fault_detc_en=0 → no flag and clean parity.
- **Injection.** inj_arm=1 with inj_dbl=0, then one beat with data 0 → m_data=1, m_parity=8'h00. Next beat is clean. Repeat with inj_dbl=1 → m_data=3.
- **Counter edges.** Force 256 faulted beats → fault_cnt stays 255. fault_clr coinciding with a fault → sticky=1, cnt=1.
- **Reset and bypass.** Assert rst with both stages full → next cycle m_valid=0, s_ready=1, counters 0. bypass=1 with data all-ones → m_parity=0, m_fault=0.
